// File: rtl/elevator_request_scheduler_if.sv
// Elevator scheduler bus: call inputs, controller status,
// and the registered floor request back to the controller.
interface elevator_request_scheduler_if #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [FLOOR_W-1:0]    target_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  busy;

    modport slave (
        input  call_req, current_floor, door_open,
        output target_floor, pending, dir_up, busy
    );

    modport master (
        output call_req, current_floor, door_open,
        input  target_floor, pending, dir_up, busy
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches floor calls, picks the next
// floor to serve and holds a minimum dwell at each served stop.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2,
    parameter int MIN_DWELL  = 8
) (
    input  logic clk,
    input  logic reset,
    elevator_request_scheduler_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SWEEP_UP = 3'd1;
    localparam logic [2:0] SWEEP_DN = 3'd2;
    localparam logic [2:0] DWELL    = 3'd3;

    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [7:0] DWELL_INIT = 8'(MIN_DWELL - 1);

    logic [2:0]            state_q, state_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [FLOOR_W-1:0]    cur;
    logic [NUM_FLOORS-1:0] clr, above, below;
    logic [FLOOR_W-1:0]    next_up, next_dn;
    logic                  any_up, any_dn, here_pend;
    logic                  near_up, scan_up, at_tgt, arrive;

    // Out-of-range floor reports are clamped so targets stay legal.
    always_comb begin
        cur       = (bus.current_floor > TOP) ? TOP : bus.current_floor;
        clr       = '0;
        above     = '0;
        below     = '0;
        here_pend = 1'b0;
        next_up   = TOP;
        next_dn   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr[i]   = bus.door_open && (cur == FLOOR_W'(i));
            above[i] = pend_q[i] && (FLOOR_W'(i) > cur);
            below[i] = pend_q[i] && (FLOOR_W'(i) < cur);
            if (pend_q[i] && (cur == FLOOR_W'(i))) here_pend = 1'b1;
            if (below[i]) next_dn = FLOOR_W'(i);
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above[i]) next_up = FLOOR_W'(i);
        end
        any_up  = |above;
        any_dn  = |below;
        near_up = any_up &&
                  (!any_dn || ((next_up - cur) <= (cur - next_dn)));
        scan_up = any_up && (dir_q || !any_dn);
        at_tgt  = (cur == target_q);
        arrive  = bus.door_open && at_tgt;
        pend_d  = (pend_q | bus.call_req) & ~clr;
    end

    // SCAN policy; a SWEEP waits in place for the door when parked
    // on its still-pending target so the stop is not skipped.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                target_d = cur;
                if (near_up) begin
                    state_d  = SWEEP_UP;
                    target_d = next_up;
                    dir_d    = 1'b1;
                end else if (any_dn) begin
                    state_d  = SWEEP_DN;
                    target_d = next_dn;
                    dir_d    = 1'b0;
                end
            end
            SWEEP_UP: begin
                if (arrive) begin
                    state_d  = DWELL;
                    target_d = cur;
                    cnt_d    = DWELL_INIT;
                end else if (at_tgt && here_pend) begin
                    target_d = target_q;
                end else if (any_up) begin
                    target_d = next_up;
                end else if (any_dn) begin
                    state_d  = SWEEP_DN;
                    target_d = next_dn;
                    dir_d    = 1'b0;
                end else begin
                    state_d  = IDLE;
                    target_d = cur;
                end
            end
            SWEEP_DN: begin
                if (arrive) begin
                    state_d  = DWELL;
                    target_d = cur;
                    cnt_d    = DWELL_INIT;
                end else if (at_tgt && here_pend) begin
                    target_d = target_q;
                end else if (any_dn) begin
                    target_d = next_dn;
                end else if (any_up) begin
                    state_d  = SWEEP_UP;
                    target_d = next_up;
                    dir_d    = 1'b1;
                end else begin
                    state_d  = IDLE;
                    target_d = cur;
                end
            end
            DWELL: begin
                target_d = cur;
                if (cnt_q == 8'd0) begin
                    if (scan_up) begin
                        state_d  = SWEEP_UP;
                        target_d = next_up;
                        dir_d    = 1'b1;
                    end else if (any_dn) begin
                        state_d  = SWEEP_DN;
                        target_d = next_dn;
                        dir_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.door_open) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                target_d = cur;
            end
        endcase
        busy_d = (state_d != IDLE) || (pend_d != '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            pend_q   <= '0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.target_floor = target_q;
    assign bus.pending      = pend_q;
    assign bus.dir_up       = dir_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for the SCAN scheduler: each driven cycle
// pushes its expected outputs, the monitor pops and compares.
module tb_elevator_request_scheduler;
    localparam int NF = 4;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    elevator_request_scheduler_if #(
        .NUM_FLOORS(NF), .FLOOR_W(FW)
    ) bus ();

    elevator_request_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .MIN_DWELL(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] p;
        logic       d;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Monitor: compare registered outputs 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("target", 8'(bus.target_floor), 8'(e.t));
            chk("pending", 8'(bus.pending), 8'(e.p));
            chk("dir_up", 8'(bus.dir_up), 8'(e.d));
            chk("busy", 8'(bus.busy), 8'(e.b));
        end
    end

    task automatic step(input logic rst, input logic [3:0] c,
                        input logic [1:0] f, input logic dr,
                        input logic [1:0] et, input logic [3:0] ep,
                        input logic ed, input logic eb);
        reset             = rst;
        bus.call_req      = c;
        bus.current_floor = f;
        bus.door_open     = dr;
        q.push_back('{t: et, p: ep, d: ed, b: eb});
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Call to floor 3 from floor 0, dwell with a 3-cycle door close
        step(1, 4'b0000, 0, 1, 0, 4'b0000, 1, 0);
        step(0, 4'b1000, 0, 1, 0, 4'b1000, 1, 1);
        step(0, 4'b0000, 0, 1, 3, 4'b1000, 1, 1);
        step(0, 4'b0000, 0, 0, 3, 4'b1000, 1, 1);
        step(0, 4'b0000, 1, 0, 3, 4'b1000, 1, 1);
        step(0, 4'b0000, 2, 0, 3, 4'b1000, 1, 1);
        step(0, 4'b0000, 3, 0, 3, 4'b1000, 1, 1);
        step(0, 4'b0000, 3, 1, 3, 4'b0000, 1, 1);
        repeat (2) step(0, 4'b0000, 3, 1, 3, 4'b0000, 1, 1);
        repeat (3) step(0, 4'b0000, 3, 0, 3, 4'b0000, 1, 1);
        repeat (5) step(0, 4'b0000, 3, 1, 3, 4'b0000, 1, 1);
        step(0, 4'b0000, 3, 1, 3, 4'b0000, 1, 0);

        // Equal distance from floor 1: up to 2 first, then down to 0
        step(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 0);
        step(0, 4'b0101, 1, 0, 1, 4'b0101, 1, 1);
        step(0, 4'b0000, 1, 0, 2, 4'b0101, 1, 1);
        step(0, 4'b0000, 2, 0, 2, 4'b0101, 1, 1);
        step(0, 4'b0000, 2, 1, 2, 4'b0001, 1, 1);
        repeat (7) step(0, 4'b0000, 2, 1, 2, 4'b0001, 1, 1);
        step(0, 4'b0000, 2, 1, 0, 4'b0001, 0, 1);
        step(0, 4'b0000, 1, 0, 0, 4'b0001, 0, 1);
        step(0, 4'b0000, 0, 0, 0, 4'b0001, 0, 1);
        step(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1);
        repeat (7) step(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1);
        step(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 0);

        // Call for the floor with the door already open is absorbed
        repeat (5) step(0, 4'b0100, 2, 1, 2, 4'b0000, 0, 0);
        step(0, 4'b0000, 2, 1, 2, 4'b0000, 0, 0);

        // Preemption by a closer call, SCAN continuation, reversal
        step(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 0);
        step(0, 4'b1000, 1, 0, 1, 4'b1000, 1, 1);
        step(0, 4'b0001, 1, 0, 3, 4'b1001, 1, 1);
        step(0, 4'b0100, 1, 0, 3, 4'b1101, 1, 1);
        step(0, 4'b0000, 1, 0, 2, 4'b1101, 1, 1);
        step(0, 4'b0000, 2, 0, 2, 4'b1101, 1, 1);
        step(0, 4'b0000, 2, 1, 2, 4'b1001, 1, 1);
        repeat (7) step(0, 4'b0000, 2, 1, 2, 4'b1001, 1, 1);
        step(0, 4'b0000, 2, 1, 3, 4'b1001, 1, 1);
        step(0, 4'b0000, 3, 0, 3, 4'b1001, 1, 1);
        step(0, 4'b0000, 3, 1, 3, 4'b0001, 1, 1);
        repeat (7) step(0, 4'b0000, 3, 1, 3, 4'b0001, 1, 1);
        step(0, 4'b0000, 3, 1, 0, 4'b0001, 0, 1);
        step(0, 4'b0000, 2, 0, 0, 4'b0001, 0, 1);
        step(1, 4'b0010, 2, 0, 0, 4'b0000, 1, 0);

        // Reset in the middle of an upward sweep
        step(0, 4'b1100, 0, 0, 0, 4'b1100, 1, 1);
        step(0, 4'b0000, 0, 0, 2, 4'b1100, 1, 1);
        step(0, 4'b0000, 1, 0, 2, 4'b1100, 1, 1);
        step(1, 4'b0010, 1, 0, 0, 4'b0000, 1, 0);
        step(0, 4'b0000, 1, 0, 1, 4'b0000, 1, 0);

        repeat (2) @(posedge clk);
        #2;
        chk("drain", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
